core_input_feeder: RTL
======================

# core_input_feeder

Input-side companion to the multicore output arbiter. It buffers an upstream stream of signed 32-bit samples in a FIFO and serves them one word at a time to NCORES ssf cores over the shared `io_in` bus, in response to each core's `req_in` code. A round-robin arbiter grants at most one requesting core per cycle. The block sits between the sample source and the multicore array.

## Interface
- NCORES, 25, number of cores served (2..32)
- DW, 32, sample width
- DEPTH, 16, FIFO depth in words (power of two, ≥2)
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- s_data  in  DW  upstream sample, signed
- s_valid  in  1  upstream sample valid
- s_ready  out  1  FIFO can accept a word
- req_in  in  2*NCORES  per-core request code; core k uses bits [2k+1:2k]
- io_in  out  DW  shared sample bus to all cores, signed
- grant  out  NCORES  one-hot; bit k set means `io_in` is the word for core k this cycle
- level  out  $clog2(DEPTH)+1  FIFO occupancy
- starve_cnt  out  16  saturating count of starved cycles (see Configuration)

## Operation
- Request codes: 2'd1 means the core wants the next word; 2'd0, 2'd2 and 2'd3 mean idle. An idle code never gets a grant.
- FIFO:
  - Push when s_valid && s_ready, with s_ready = !full, taken from registered state.
  - Pop occurs exactly when a grant is issued.
  - Push and pop in the same cycle leave `level` unchanged.
  - When full, s_ready = 0 regardless of a same-cycle pop.
  - No bypass: a word pushed into an empty FIFO becomes eligible the following cycle.
- Eligibility: core k is eligible when req_in[k] == 2'd1 and k was not granted in the previous cycle. This mask stops a core that has not yet dropped its request from receiving a double grant.
- Arbitration happens only when the FIFO is not empty and at least one core is eligible.
  - Round-robin search starts from pointer `rr`.
  - The winner w takes the FIFO head; `rr` becomes (w+1) mod NCORES.
  - With no grant, `rr` holds.
- Output registers, loaded on a grant:
  - `io_in` ← FIFO head.
  - `grant` ← one-hot(w).
- Without a grant:
  - `grant` ← 0.
  - `io_in` holds its last value.
- Core handshake:
  - A core holds 2'd1 until it samples its grant bit high.
  - It may then drop the request or keep it high to ask for another word. A core that keeps requesting is eligible again two cycles after its previous grant.
- Reset (rst low, asynchronous):
  - FIFO emptied; `level` = 0; `rr` = 0.
  - `grant` = 0; `io_in` = 0; previous-grant mask = 0; `starve_cnt` = 0.
  - s_ready = 1 once out of reset.
  - Any word in flight is discarded. A grant asserted when reset hits is cleared immediately.

## Timing
- Request to delivery: req_in sampled at edge t gives grant/io_in valid after edge t (one cycle).
- Upstream to delivery, empty FIFO: push at edge t makes the word eligible at t+1, so it is delivered after edge t+1 (two-cycle minimum).
- Throughput: one word per cycle when at least two cores alternate requests; a single core alone gets one word every two cycles.
- Pointer wrap: rr = NCORES-1 searches NCORES-1, 0, 1, … in that order.
- `level` and s_ready are registered and reflect state after the last edge.

## Configuration
- FEEDER_STARVE_CNT_EN
  - Defined: `starve_cnt` increments each cycle in which any req_in code equals 2'd1 while the FIFO is empty. It saturates at 16'hFFFF and clears only on reset.
  - Undefined: the counter logic is removed and `starve_cnt` is tied to 0.

## Test plan
- Reset, then push 0x11, 0x22, 0x33 with no requests → level = 3, grant = 0, io_in = 0, s_ready = 1.
- FIFO holding 0x11, 0x22; cores 3 and 7 request together with rr = 0 → core 3 gets 0x11, next cycle core 7 gets 0x22, then rr = 8.
- Core 5 alone holds 2'd1 with 4 words queued → grants on alternate cycles only (masking rule); four words delivered over 8 cycles.
- Fill to DEPTH=16 → s_ready = 0; one grant → s_ready = 1 the next cycle and level = 15; simultaneous push and pop at level 8 → level stays 8.
- Cores 24 and 0 request with rr = 24 → 24 granted first, then 0; code 2'd2 on core 1 → never granted.
- With FEEDER_STARVE_CNT_EN: FIFO empty, core 2 requests for 10 cycles → starve_cnt = 10. Async reset pulsed mid-grant → grant, io_in, starve_cnt = 0 immediately.

Source files
------------

// File: rtl/core_input_feeder_if.sv
// rtl/core_input_feeder_if.sv - sample source / core array bus of core_input_feeder
// master drives samples and request codes, slave is the feeder.
interface core_input_feeder_if #(
  parameter int NCORES = 25,
  parameter int DW     = 32,
  parameter int DEPTH  = 16
);
  logic signed [DW-1:0]     s_data;
  logic                     s_valid;
  logic                     s_ready;
  logic [2*NCORES-1:0]      req_in;
  logic signed [DW-1:0]     io_in;
  logic [NCORES-1:0]        grant;
  logic [$clog2(DEPTH):0]   level;
  logic [15:0]              starve_cnt;

  modport master (
    output s_data, s_valid, req_in,
    input  s_ready, io_in, grant, level, starve_cnt
  );

  modport slave (
    input  s_data, s_valid, req_in,
    output s_ready, io_in, grant, level, starve_cnt
  );
endinterface

// File: rtl/core_input_feeder.sv
// rtl/core_input_feeder.sv - FIFO-buffered round-robin sample feeder for NCORES cores
// Optional starvation counter: define FEEDER_STARVE_CNT_EN.
module core_input_feeder #(
  parameter int NCORES = 25,
  parameter int DW     = 32,
  parameter int DEPTH  = 16
) (
  input  logic               clk,
  input  logic               rst,
  core_input_feeder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = (NCORES > 1) ? $clog2(NCORES) : 1;

  logic [DW-1:0]     mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic [RW-1:0]     rr_q, rr_d;
  logic [NCORES-1:0] grant_q, grant_d;
  logic [DW-1:0]     io_q, io_d;

  logic [NCORES-1:0] eligible;
  logic [RW-1:0]     winner;
  logic              found;
  logic              full, empty, push, pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = bus.s_valid && !full;

  // grant_q doubles as the previous-grant mask against double grants
  always_comb begin
    eligible = '0;
    for (int k = 0; k < NCORES; k++) begin
      eligible[k] = (bus.req_in[2*k +: 2] == 2'd1) && !grant_q[k];
    end
  end

  always_comb begin
    int          idx;
    logic [RW-1:0] sel;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    sel    = '0;
    for (int i = 0; i < NCORES; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= NCORES) begin
        idx = idx - NCORES;
      end
      sel = RW'(idx);
      if (!found && eligible[sel]) begin
        found  = 1'b1;
        winner = sel;
      end
    end
  end

  assign pop = found && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rr_d     = rr_q;
    grant_d  = '0;
    io_d     = io_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      io_d     = mem_q[rd_ptr_q];
      grant_d  = NCORES'(1) << winner;
      rr_d     = (winner == RW'(NCORES-1)) ? '0 : winner + RW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + (AW+1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rr_q     <= '0;
      grant_q  <= '0;
      io_q     <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rr_q     <= rr_d;
      grant_q  <= grant_d;
      io_q     <= io_d;
    end
  end

  // storage needs no reset: the pointers define what is valid
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.s_data;
    end
  end

  assign bus.s_ready = !full;
  assign bus.level   = count_q;
  assign bus.grant   = grant_q;
  assign bus.io_in   = io_q;

`ifdef FEEDER_STARVE_CNT_EN
  logic        any_req;
  logic [15:0] starve_q, starve_d;

  always_comb begin
    any_req = 1'b0;
    for (int k = 0; k < NCORES; k++) begin
      if (bus.req_in[2*k +: 2] == 2'd1) begin
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (any_req && empty && (starve_q != 16'hFFFF)) begin
      starve_d = starve_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  assign bus.starve_cnt = starve_q;
`else
  assign bus.starve_cnt = '0;
`endif
endmodule
